spmv_rr_arbiter: RTL

- Round-robin, packet-locking arbiter sharing one downstream stream port among WIDTH requesters in the SpMV merge datapath.
- Uses isolate-lowest-set-bit (req & ~(req-1)) on a rotated/masked request vector to pick the winner.
- Holds the grant until the winner's last beat transfers.
- Registered one-hot grant, encoded grant id and per-beat transfer strobe for downstream mux control.

---
 rtl/spmv_rr_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spmv_rr_arbiter.sv
// Round-robin, packet-locking arbiter that shares one downstream stream port
// among WIDTH requesters in the SpMV merge datapath.
module spmv_rr_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ID_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic             xfer
);

  localparam logic [ID_W-1:0] PTR_RST = ID_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic             xfer_c;
  logic             release_c;
  logic [ID_W-1:0]  arb_ptr_c;
  logic [WIDTH-1:0] cand_c;
  logic [WIDTH-1:0] mask_c;
  logic [WIDTH-1:0] masked_c;
  logic [WIDTH-1:0] win_oh_c;
  logic [ID_W-1:0]  win_id_c;

  // Isolate the lowest set bit of a request vector.
  function automatic logic [WIDTH-1:0] lowest_bit(input logic [WIDTH-1:0] v);
    return v & ~(v - WIDTH'(1));
  endfunction

  function automatic logic [ID_W-1:0] onehot_to_id(input logic [WIDTH-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (oh[i]) id = id | ID_W'(i);
    end
    return id;
  endfunction

  // A beat moves only while a grant is held and both ends are ready.
  assign xfer_c    = ~rst & gnt_vld_q & req[gnt_id_q] & out_ready;
  assign release_c = xfer_c & last[gnt_id_q];

  // On release the releaser becomes the new pointer and is excluded this cycle.
  always_comb begin
    arb_ptr_c = ptr_q;
    cand_c    = req;
    if (state_q == LOCK) begin
      arb_ptr_c = gnt_id_q;
      cand_c    = req & ~gnt_q;
    end
  end

  assign mask_c   = ({WIDTH{1'b1}} << arb_ptr_c) << 1;
  assign masked_c = cand_c & mask_c;
  assign win_oh_c = (masked_c != '0) ? lowest_bit(masked_c) : lowest_bit(cand_c);
  assign win_id_c = onehot_to_id(win_oh_c);

  // Next-state and grant logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (cand_c != '0) begin
          gnt_d     = win_oh_c;
          gnt_id_d  = win_id_c;
          gnt_vld_d = 1'b1;
          state_d   = LOCK;
        end
      end
      LOCK: begin
        if (release_c) begin
          ptr_d = gnt_id_q;
          if (cand_c != '0) begin
            gnt_d    = win_oh_c;
            gnt_id_d = win_id_c;
          end else begin
            gnt_d     = '0;
            gnt_id_d  = '0;
            gnt_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        gnt_d     = '0;
        gnt_id_d  = '0;
        gnt_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= PTR_RST;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
  assign xfer    = xfer_c;

  a_params: assert property (@(posedge clk)
    (WIDTH >= 2) && (ID_W == $clog2(WIDTH)));

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q));

  a_gnt_id_match: assert property (@(posedge clk) disable iff (rst)
    (gnt_vld_q == (gnt_q != '0)) &&
    (gnt_vld_q ? gnt_q[gnt_id_q] : (gnt_id_q == '0)));

endmodule
